// File: rtl/ring_pkg.sv
// Shared definitions for the rotating ring-pattern generator/checker pair:
// FSM state encoding, default pattern constants and the rotate-left helper.
package ring_pkg;

  localparam int unsigned DEF_WIDTH = 8;
  localparam logic [DEF_WIDTH-1:0] DEF_SEED = 8'b01010101;
  localparam int unsigned MAX_W = 64;

  typedef enum logic [1:0] {HUNT, VERIFY, LOCKED} state_t;

  // Rotate left by one within the low w bits; callers zero-extend into MAX_W.
  function automatic logic [MAX_W-1:0] rotl(input logic [MAX_W-1:0] x,
                                            input int unsigned     w);
    logic [MAX_W-1:0] mask;
    mask = {MAX_W{1'b1}};
    mask = mask >> (MAX_W - w);
    return ((x << 1) | (x >> (w - 1))) & mask;
  endfunction

endpackage

// File: rtl/ring_rot_match.sv
// Combinational comparator: does x equal some rotation of seed, and which one
// (lowest rotation count wins, so periodic seeds report the index mod period).
module ring_rot_match
  import ring_pkg::*;
#(
  parameter int unsigned WIDTH = DEF_WIDTH,
  parameter int unsigned IDX_W = $clog2(WIDTH)
) (
  input  logic [WIDTH-1:0] x,
  input  logic [WIDTH-1:0] seed,
  output logic             hit,
  output logic [IDX_W-1:0] idx
);

  logic [WIDTH-1:0] rot;

  always_comb begin
    hit = 1'b0;
    idx = '0;
    rot = seed;
    for (int unsigned k = 0; k < WIDTH; k++) begin
      if (!hit && (x == rot)) begin
        hit = 1'b1;
        idx = IDX_W'(k);
      end
      rot = WIDTH'(rotl(MAX_W'(rot), WIDTH));
    end
  end

endmodule

// File: rtl/ring_pattern_checker.sv
// Receive-side monitor for the rotating ring pattern: locks to the rotate-left
// sequence, reports rotation phase, and flags/counts sequence errors.
module ring_pattern_checker
  import ring_pkg::*;
#(
  parameter int unsigned       WIDTH      = DEF_WIDTH,
  parameter logic [WIDTH-1:0]  SEED       = DEF_SEED,
  parameter int unsigned       LOCK_CNT   = 4,
  parameter int unsigned       UNLOCK_CNT = 3,
  parameter int unsigned       ERR_W      = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  input  logic [WIDTH-1:0]         T_in,
  input  logic                     clear_err,
  output logic                     locked,
  output logic [$clog2(WIDTH)-1:0] phase,
  output logic                     phase_valid,
  output logic                     err_pulse,
  output logic [ERR_W-1:0]         err_count
);

  localparam int unsigned PW  = $clog2(WIDTH);
  localparam int unsigned GCW = $clog2(LOCK_CNT + 1);
  localparam int unsigned BCW = $clog2(UNLOCK_CNT + 1);

  state_t           state_q, state_d;
  logic [WIDTH-1:0] exp_q, exp_d;
  logic [GCW-1:0]   good_cnt_q, good_cnt_d;
  logic [BCW-1:0]   bad_cnt_q, bad_cnt_d;
  logic             locked_d, phase_valid_d, err_pulse_d;
  logic [PW-1:0]    phase_d;
  logic [ERR_W-1:0] err_count_d;

  logic             hit;
  logic [PW-1:0]    idx;
  logic             good, bad;
  logic [WIDTH-1:0] rot_in, rot_exp;

  ring_rot_match #(.WIDTH(WIDTH), .IDX_W(PW)) u_match (
    .x    (T_in),
    .seed (SEED),
    .hit  (hit),
    .idx  (idx)
  );

  assign good    = in_valid && (T_in == exp_q);
  assign bad     = in_valid && (T_in != exp_q);
  assign rot_in  = WIDTH'(rotl(MAX_W'(T_in), WIDTH));
  assign rot_exp = WIDTH'(rotl(MAX_W'(exp_q), WIDTH));

  always_comb begin
    state_d       = state_q;
    exp_d         = exp_q;
    good_cnt_d    = good_cnt_q;
    bad_cnt_d     = bad_cnt_q;
    locked_d      = locked;
    phase_d       = phase;
    phase_valid_d = phase_valid;
    err_pulse_d   = 1'b0;
    err_count_d   = clear_err ? '0 : err_count;

    unique case (state_q)
      HUNT: begin
        if (in_valid && hit) begin
          exp_d      = rot_in;
          good_cnt_d = '0;
          state_d    = VERIFY;
        end
      end
      VERIFY: begin
        if (good) begin
          exp_d      = rot_in;
          good_cnt_d = good_cnt_q + GCW'(1);
          if (good_cnt_q == GCW'(LOCK_CNT - 1)) begin
            state_d   = LOCKED;
            locked_d  = 1'b1;
            bad_cnt_d = '0;
          end
        end else if (bad) begin
          if (hit) begin
            exp_d      = rot_in;
            good_cnt_d = '0;
          end else begin
            state_d = HUNT;
          end
        end
      end
      LOCKED: begin
        if (in_valid) begin
          if (hit) phase_d = idx;
          phase_valid_d = hit;
        end
        if (good) begin
          bad_cnt_d = '0;
          exp_d     = rot_in;
        end else if (bad) begin
          // Flywheel: keep advancing the expected pattern through the error.
          exp_d       = rot_exp;
          err_pulse_d = 1'b1;
          if (!clear_err && (err_count != '1)) err_count_d = err_count + ERR_W'(1);
          bad_cnt_d = bad_cnt_q + BCW'(1);
          if (bad_cnt_q == BCW'(UNLOCK_CNT - 1)) begin
            state_d       = HUNT;
            locked_d      = 1'b0;
            phase_valid_d = 1'b0;
          end
        end
      end
      default: state_d = HUNT;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= HUNT;
      exp_q       <= '0;
      good_cnt_q  <= '0;
      bad_cnt_q   <= '0;
      locked      <= 1'b0;
      phase       <= '0;
      phase_valid <= 1'b0;
      err_pulse   <= 1'b0;
      err_count   <= '0;
    end else begin
      state_q     <= state_d;
      exp_q       <= exp_d;
      good_cnt_q  <= good_cnt_d;
      bad_cnt_q   <= bad_cnt_d;
      locked      <= locked_d;
      phase       <= phase_d;
      phase_valid <= phase_valid_d;
      err_pulse   <= err_pulse_d;
      err_count   <= err_count_d;
    end
  end

endmodule
